// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multiport register file and its dump engine.
package regfile_pkg;

    // Dump engine states: wait for a request, stream words, pulse completion.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    localparam int NB_ADDR_DEFAULT = 5;
    localparam int DEPTH           = 2 ** NB_ADDR_DEFAULT;

    // Number of registers addressed by an nb_addr-bit address.
    function automatic int depth_of(input int nb_addr);
        return 2 ** nb_addr;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Debug dump channel between the register file (slave) and the debug unit (master).
interface regfile_multiport_if #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32
);
    logic               i_dump_start;
    logic               i_dump_ready;
    logic               o_dump_valid;
    logic [NB_ADDR-1:0] o_dump_addr;
    logic [NB_DATA-1:0] o_dump_data;
    logic               o_dump_busy;
    logic               o_dump_done;

    modport master (
        output i_dump_start, i_dump_ready,
        input  o_dump_valid, o_dump_addr, o_dump_data, o_dump_busy, o_dump_done
    );

    modport slave (
        input  i_dump_start, i_dump_ready,
        output o_dump_valid, o_dump_addr, o_dump_data, o_dump_busy, o_dump_done
    );
endinterface

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks every register address once over a valid/ready handshake,
// then pulses done for one cycle. The parent supplies rd_data for rd_addr.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ready,
    input  logic [NB_DATA-1:0] rd_data,
    output logic [NB_ADDR-1:0] rd_addr,
    output logic               valid,
    output logic [NB_ADDR-1:0] addr,
    output logic [NB_DATA-1:0] data,
    output logic               busy,
    output logic               done
);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

    dump_state_t state;

    // While sending, look up the next word so it is ready at the handshake edge.
    assign rd_addr = (state == ST_SEND) ? addr + NB_ADDR'(1) : '0;

    // Dump sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
            addr  <= '0;
            data  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr  <= '0;
                        data  <= rd_data;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (valid && ready) begin
                        if (addr == LAST_ADDR) begin
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            addr <= rd_addr;
                            data <= rd_data;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/regfile_multiport.sv
// MIPS general-purpose register file: N_RD registered read ports, one write port,
// optional hard-wired zero register and a debug dump channel.
// Optional feature: define REGFILE_WR_BYPASS_EN for write-first forwarding on the
// read ports; otherwise a same-cycle read of the written address is read-first.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [NB_ADDR-1:0]      i_wr_addr,
    input  logic [NB_DATA-1:0]      i_wr_data,
    input  logic [N_RD*NB_ADDR-1:0] i_rd_addr,
    output logic [N_RD*NB_DATA-1:0] o_rd_data,
    regfile_multiport_if.slave      dump
);
    localparam int N_REGS  = depth_of(NB_ADDR);
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [NB_DATA-1:0]      mem [N_REGS];
    logic [N_RD*NB_DATA-1:0] rd_next;
    logic                    wr_ok;
    logic [NB_ADDR-1:0]      dump_rd_addr;
    logic [NB_DATA-1:0]      dump_rd_data;

    assign wr_ok = i_we && !(ZERO_EN && (i_wr_addr == '0));

    // Register array write; the whole array clears on reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        // NOTE: the array is reset, so it maps to flops rather than a RAM macro; registers must read 0 after reset.
        if (!i_rst_n) begin
            for (int i = 0; i < N_REGS; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Next read-port values: zero register first, then optional forwarding, then the array.
    always_comb begin
        // NOTE: default every output first so no path leaves rd_next unassigned (no latch).
        rd_next = '0;
        for (int k = 0; k < N_RD; k++) begin
            if (ZERO_EN && (i_rd_addr[k*NB_ADDR +: NB_ADDR] == '0)) begin
                rd_next[k*NB_DATA +: NB_DATA] = '0;
`ifdef REGFILE_WR_BYPASS_EN
            end else if (i_we && (i_rd_addr[k*NB_ADDR +: NB_ADDR] == i_wr_addr)) begin
                rd_next[k*NB_DATA +: NB_DATA] = i_wr_data;
`else
`endif
            end else begin
                rd_next[k*NB_DATA +: NB_DATA] = mem[i_rd_addr[k*NB_ADDR +: NB_ADDR]];
            end
        end
    end

    // Registered read ports: one cycle of latency.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) o_rd_data <= '0;
        else          o_rd_data <= rd_next;
    end

    assign dump_rd_data = (ZERO_EN && (dump_rd_addr == '0)) ? '0 : mem[dump_rd_addr];

    regfile_dump_fsm #(
        .NB_ADDR (NB_ADDR),
        .NB_DATA (NB_DATA)
    ) u_dump_fsm (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .start   (dump.i_dump_start),
        .ready   (dump.i_dump_ready),
        .rd_data (dump_rd_data),
        .rd_addr (dump_rd_addr),
        .valid   (dump.o_dump_valid),
        .addr    (dump.o_dump_addr),
        .data    (dump.o_dump_data),
        .busy    (dump.o_dump_busy),
        .done    (dump.o_dump_done)
    );
endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: read/write, zero register, same-cycle
// write/read, full dumps with steady and toggling ready, and reset mid-dump.
module tb_regfile_multiport;
    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int N_RD    = 2;
    localparam int DEPTH   = 32;
`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [NB_ADDR-1:0] addr;
        logic [NB_DATA-1:0] data;
    } word_t;

    logic                    clk = 1'b0;
    logic                    i_rst_n = 1'b0;
    logic                    i_we = 1'b0;
    logic [NB_ADDR-1:0]      i_wr_addr = '0;
    logic [NB_DATA-1:0]      i_wr_data = '0;
    logic [N_RD*NB_ADDR-1:0] i_rd_addr = '0;
    logic [N_RD*NB_DATA-1:0] o_rd_data;

    regfile_multiport_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) dump_if ();

    regfile_multiport #(
        .NB_DATA  (NB_DATA),
        .NB_ADDR  (NB_ADDR),
        .N_RD     (N_RD),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_we      (i_we),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data),
        .dump      (dump_if)
    );

    always #5 clk = ~clk;

    logic [NB_DATA-1:0] mdl [DEPTH];
    logic [NB_DATA-1:0] rd_q [$];
    word_t              dump_q [$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NB_DATA-1:0] exp_rd(input logic [NB_ADDR-1:0] a, input logic we,
                                                  input logic [NB_ADDR-1:0] wa, input logic [NB_DATA-1:0] wd);
        if (a == '0) return '0;
        if (BYPASS && we && (a == wa)) return wd;
        return mdl[a];
    endfunction

    // One clock: drive ports, queue expected read data, update model, then compare.
    task automatic step(input logic we, input logic [NB_ADDR-1:0] wa, input logic [NB_DATA-1:0] wd,
                        input logic [NB_ADDR-1:0] ra0, input logic [NB_ADDR-1:0] ra1);
        i_we      = we;
        i_wr_addr = wa;
        i_wr_data = wd;
        i_rd_addr = {ra1, ra0};
        rd_q.push_back(exp_rd(ra0, we, wa, wd));
        rd_q.push_back(exp_rd(ra1, we, wa, wd));
        if (we && (wa != '0)) mdl[wa] = wd;
        @(posedge clk);
        #1;
        check("rd_port0", o_rd_data[NB_DATA-1:0], rd_q.pop_front());
        check("rd_port1", o_rd_data[2*NB_DATA-1:NB_DATA], rd_q.pop_front());
    endtask

    task automatic run_dump(input bit toggle_ready, input bit write_r4);
        int    cnt = 0;
        int    cyc = 0;
        bit    wrote = 0;
        bit    last;
        bit    finished = 0;
        bit    rdy;
        logic  we;
        logic [NB_ADDR-1:0] wa;
        logic [NB_DATA-1:0] wd;
        word_t w;
        dump_q.delete();
        dump_if.i_dump_ready = 1'b1;
        dump_if.i_dump_start = 1'b1;
        w.addr = '0;
        w.data = mdl[0];
        dump_q.push_back(w);
        step(1'b0, '0, '0, '0, 5'd4);
        dump_if.i_dump_start = 1'b0;
        check("dump_valid_after_start", dump_if.o_dump_valid, 1);
        while (!finished && cyc < 400) begin
            rdy = toggle_ready ? (cyc % 2 == 0) : 1'b1;
            dump_if.i_dump_ready = rdy;
            we = 1'b0; wa = '0; wd = '0;
            if (write_r4 && !wrote && dump_if.o_dump_valid && dump_if.o_dump_addr == 5'd4) begin
                we = 1'b1; wa = 5'd4; wd = 32'hFF; wrote = 1;
            end
            last = 0;
            if (dump_if.o_dump_valid && rdy) begin
                w = dump_q.pop_front();
                check("dump_addr", dump_if.o_dump_addr, w.addr);
                check("dump_data", dump_if.o_dump_data, w.data);
                check("dump_busy", dump_if.o_dump_busy, 1);
                if (cnt < DEPTH - 1) begin
                    w.addr = NB_ADDR'(cnt + 1);
                    w.data = mdl[cnt + 1];
                    dump_q.push_back(w);
                end else begin
                    last = 1;
                end
                cnt++;
            end
            step(we, wa, wd, NB_ADDR'(cyc % DEPTH), 5'd4);
            if (last) begin
                check("done_pulse", dump_if.o_dump_done, 1);
                check("valid_after_last", dump_if.o_dump_valid, 0);
                check("busy_after_last", dump_if.o_dump_busy, 0);
                step(1'b0, '0, '0, '0, '0);
                check("done_one_cycle", dump_if.o_dump_done, 0);
                finished = 1;
            end
            cyc++;
        end
        check("dump_word_count", cnt, DEPTH);
        dump_if.i_dump_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dump_if.i_dump_start = 1'b0;
        dump_if.i_dump_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        // Reset state
        #12;
        check("reset_rd_data", o_rd_data, 0);
        check("reset_valid", dump_if.o_dump_valid, 0);
        check("reset_busy", dump_if.o_dump_busy, 0);
        check("reset_done", dump_if.o_dump_done, 0);
        check("reset_dump_data", dump_if.o_dump_data, 0);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;

        // 1: all addresses read zero on both ports
        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, NB_ADDR'(a), NB_ADDR'(DEPTH - 1 - a));

        // 2: basic write/read and zero register
        step(1'b1, 5'd5, 32'hDEADBEEF, '0, '0);
        step(1'b0, '0, '0, 5'd5, 5'd5);
        step(1'b1, 5'd0, 32'h1234, '0, '0);
        step(1'b0, '0, '0, 5'd0, 5'd5);

        // 3: same-cycle write and read of r7
        step(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        step(1'b0, '0, '0, 5'd7, 5'd0);

        // 4: preload r[i] = i*3, dump with ready held high
        for (int i = 0; i < DEPTH; i++) step(1'b1, NB_ADDR'(i), 32'(i * 3), NB_ADDR'(i), 5'd0);
        run_dump(1'b0, 1'b0);

        // 5: ready toggling, write r4 while word 4 is presented
        run_dump(1'b1, 1'b1);
        step(1'b0, '0, '0, 5'd4, 5'd9);

        // 6: reset in the middle of a dump
        dump_if.i_dump_ready = 1'b1;
        dump_if.i_dump_start = 1'b1;
        step(1'b0, '0, '0, '0, '0);
        dump_if.i_dump_start = 1'b0;
        for (int i = 0; i < 40 && !(dump_if.o_dump_valid && dump_if.o_dump_addr == 5'd10); i++)
            step(1'b0, '0, '0, '0, '0);
        check("abort_reached_addr10", dump_if.o_dump_addr, 10);
        #2;
        i_rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        #1;
        check("abort_valid", dump_if.o_dump_valid, 0);
        check("abort_busy", dump_if.o_dump_busy, 0);
        check("abort_done", dump_if.o_dump_done, 0);
        check("abort_addr", dump_if.o_dump_addr, 0);
        check("abort_rd_data", o_rd_data, 0);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, '0, 5'd5, 5'd7);
            check("idle_valid", dump_if.o_dump_valid, 0);
            check("idle_busy", dump_if.o_dump_busy, 0);
            check("idle_done", dump_if.o_dump_done, 0);
        end
        dump_if.i_dump_start = 1'b1;
        step(1'b0, '0, '0, '0, '0);
        dump_if.i_dump_start = 1'b0;
        check("restart_valid", dump_if.o_dump_valid, 1);
        check("restart_addr", dump_if.o_dump_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
